dma_mem_responder: RTL and testbench
====================================

// Module: dma_mem_responder
// PURPOSE
// - Slave/responder end of the DMA interconnect driven by the conv-core instruction scheduler (icm_dma_* master).
// - Sits between that master and a fixed-latency external word memory.
// - Accepts single-word reads/writes and generates waitreq.
// - Returns readdata in the cycle waitreq is low.
// PARAMETERS
// - MEM_ADDR_W  20  memory word-address width; ics_dma_address_i truncated to [MEM_ADDR_W-1:0]
// - RD_LATENCY  2   cycles from mem_read_o=1 to valid mem_readdata_i (>=1)
// - PF_DEPTH    4   prefetch window entries, in flight + buffered (only with DMA_RSP_PREFETCH_EN)
// PORTS
// - clock               in   1           system clock, all logic posedge
// - reset               in   1           synchronous, active-high
// - ics_dma_address_i   in   32          word address from master
// - ics_dma_cs_i        in   1           request valid
// - ics_dma_write_i     in   1           1=write, 0=read
// - ics_dma_writedata_i in   32          write data
// - ics_dma_readdata_o  out  32          read data, valid when cs&!write&!waitreq
// - ics_dma_waitreq_o   out  1           stall; master holds address/cs/write/data while high
// - mem_address_o       out  MEM_ADDR_W  memory address
// - mem_read_o          out  1           read strobe, one cycle per issued read
// - mem_write_o         out  1           write strobe
// - mem_writedata_o     out  32          memory write data (=ics_dma_writedata_i)
// - mem_readdata_i      in   32          data RD_LATENCY cycles after matching mem_read_o
// BEHAVIOUR
// - Reset:
//   - while reset=1: waitreq_o=1; readdata_o=0; mem_read_o=0; mem_write_o=0; mem_address_o=0; state=IDLE.
//   - Clears the in-flight shift register; returns issued before reset are ignored.
// - Request phase: a transfer completes in the cycle cs=1 and waitreq=0. cs=0 gives waitreq=0.
// - Write:
//   - Combinational accept when state=IDLE: mem_write_o=1, waitreq=0 same cycle, mem_address_o=address.
//   - In WAIT or RESP, a write stalls (waitreq=1) until IDLE.
// - Read FSM (prefetch off):
//   - IDLE: cs&!write -> mem_read_o=1 (comb), latch address, waitreq=1, go WAIT.
//   - WAIT: waitreq=1; RD_LATENCY-bit in-flight shift register. On return, capture mem_readdata_i into rdata_q, go RESP.
//   - RESP: if cs&!write -> waitreq=0, readdata_o=rdata_q, go IDLE. If cs=0 or write=1 -> discard rdata_q, go IDLE, waitreq=1 for a pending write.
//   - Read latency = RD_LATENCY+1 cycles of waitreq=1 (2 -> low in cycle 3).
//   - Sequential burst costs RD_LATENCY+2 cycles/word.
// - readdata_o holds its last value otherwise; it is not zeroed.
// - cs dropped during WAIT: the read completes internally; RESP discards the data.
// - Address bits [31:MEM_ADDR_W] are ignored: aliasing, no error.
// CONFIGURATION
// - Macro DMA_RSP_PREFETCH_EN.
// - Undefined: FSM above only; PF_DEPTH unused.
// - Defined: sequential read prefetch.
//   - PF_DEPTH-entry tag FIFO of issued addresses, each with valid-data bit and data; epoch counter.
//   - Demand read miss (cs&!write, FIFO head tag != address):
//     - flush FIFO, epoch++;
//     - issue address (mem_read_o=1) same cycle;
//     - then issue address+1, +2, ... one per cycle while occupancy < PF_DEPTH.
//   - Head tag==address and data valid: waitreq=0, readdata_o=head data, pop (freed slot refills next cycle).
//   - Head tag==address, data not returned: waitreq=1.
//   - Returned data is written to its entry in the return cycle and is visible next cycle; stale-epoch returns are dropped.
//   - Write: flush FIFO + epoch++ in the accept cycle. Write accepted even with reads in flight; a later read is a miss and sees new data.
//   - Issue priority: write > demand-miss read > prefetch. The prefetch address wraps modulo 2^MEM_ADDR_W.
//   - Latency: first word low in cycle RD_LATENCY+1; subsequent sequential words 1/cycle.
// TESTING
// - Reset, mem[0x10]=0xA5A5A5A5, RD_LATENCY=2, read 0x10 at cycle 0 -> mem_read_o=1 c0; waitreq 1 c0-c2, 0 c3 with readdata=0xA5A5A5A5.
// - Write 0x20 <- 0xDEADBEEF from IDLE -> mem_write_o=1, waitreq=0 same cycle; read 0x20 -> 0xDEADBEEF.
// - Prefetch on, read burst 0x100..0x107 (mem=addr) -> first word c3, then one word/cycle, data 0x100..0x107. Prefetch off -> 4 cycles/word.
// - Prefetch on, reads 0x100,0x101 then 0x200 -> 0x200 misses: flush, waitreq high 3 cycles, data=0x200; stale 0x102.. returns are never presented.
// - Prefetch on, read 0x40, write 0x41 <- 0x1234, read 0x41 -> returns 0x1234, not the prefetched old value.
// - Assert reset at cycle 1 of a read -> waitreq=1 during reset, IDLE after; late mem_readdata_i is ignored; next read 0x10 is correct.

Source files
------------

// File: rtl/dma_mem_responder_if.sv
// Signal bundle between the DMA master, the responder and the external word memory.
// The master holds address/cs/write/data stable while waitreq is high.
interface dma_mem_responder_if #(
    parameter int MEM_ADDR_W = 20
);
    logic [31:0]           ics_dma_address_i;
    logic                  ics_dma_cs_i;
    logic                  ics_dma_write_i;
    logic [31:0]           ics_dma_writedata_i;
    logic [31:0]           ics_dma_readdata_o;
    logic                  ics_dma_waitreq_o;
    logic [MEM_ADDR_W-1:0] mem_address_o;
    logic                  mem_read_o;
    logic                  mem_write_o;
    logic [31:0]           mem_writedata_o;
    logic [31:0]           mem_readdata_i;

    modport slave (
        input  ics_dma_address_i, ics_dma_cs_i, ics_dma_write_i, ics_dma_writedata_i, mem_readdata_i,
        output ics_dma_readdata_o, ics_dma_waitreq_o, mem_address_o, mem_read_o, mem_write_o, mem_writedata_o
    );

    modport master (
        output ics_dma_address_i, ics_dma_cs_i, ics_dma_write_i, ics_dma_writedata_i,
        input  ics_dma_readdata_o, ics_dma_waitreq_o
    );

    modport memory (
        input  mem_address_o, mem_read_o, mem_write_o, mem_writedata_o,
        output mem_readdata_i
    );
endinterface

// File: rtl/dma_mem_responder.sv
// DMA responder for a fixed-latency word memory: writes accept in one cycle, reads stall RD_LATENCY+1 cycles.
// DMA_RSP_PREFETCH_EN adds a PF_DEPTH-entry sequential read-ahead window (hits return with no stall).
module dma_mem_responder #(
    parameter int MEM_ADDR_W = 20,
    parameter int RD_LATENCY = 2,
    parameter int PF_DEPTH   = 4
) (
    input  logic               clock,
    input  logic               reset,
    dma_mem_responder_if.slave bus
);

    logic [MEM_ADDR_W-1:0] w_addr;
    logic                  w_rd_req;
    logic                  w_wr_req;
    logic                  w_issue;
    logic [MEM_ADDR_W-1:0] w_issue_addr;
    logic                  w_mem_write;
    logic                  w_rd_done;
    logic [31:0]           w_rd_data;
    logic                  w_waitreq;
    logic                  w_ret;
    logic [RD_LATENCY-1:0] r_inflight;
    logic [31:0]           r_last_rdata;

    assign w_addr   = bus.ics_dma_address_i[MEM_ADDR_W-1:0];
    assign w_rd_req = bus.ics_dma_cs_i & ~bus.ics_dma_write_i;
    assign w_wr_req = bus.ics_dma_cs_i & bus.ics_dma_write_i;
    assign w_ret    = r_inflight[RD_LATENCY-1];

    // One bit per issued read; the top bit marks the cycle its data is on mem_readdata_i.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_inflight   <= '0;
            r_last_rdata <= '0;
        end else begin
            r_inflight <= (r_inflight << 1) | RD_LATENCY'(w_issue);
            if (w_rd_done) r_last_rdata <= w_rd_data;
        end
    end

    assign bus.ics_dma_waitreq_o  = w_waitreq;
    assign bus.ics_dma_readdata_o = reset ? '0 : (w_rd_done ? w_rd_data : r_last_rdata);
    assign bus.mem_address_o      = reset ? '0 : w_issue_addr;
    assign bus.mem_read_o         = w_issue;
    assign bus.mem_write_o        = w_mem_write;
    assign bus.mem_writedata_o    = bus.ics_dma_writedata_i;

`ifdef DMA_RSP_PREFETCH_EN
    localparam int PTR_W   = (PF_DEPTH > 1) ? $clog2(PF_DEPTH) : 1;
    localparam int CNT_W   = $clog2(PF_DEPTH + 1);
    // Wide enough that a return can never see its epoch value come round again.
    localparam int EPOCH_W = $clog2(RD_LATENCY + 1) + 1;

    logic [MEM_ADDR_W-1:0] r_tag [PF_DEPTH];
    logic [31:0]           r_data [PF_DEPTH];
    logic [PF_DEPTH-1:0]   r_dv;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [CNT_W-1:0]      r_count;
    logic [EPOCH_W-1:0]    r_epoch;
    logic [EPOCH_W-1:0]    r_pipe_epoch [RD_LATENCY];
    logic [PTR_W-1:0]      r_pipe_slot [RD_LATENCY];
    logic [MEM_ADDR_W-1:0] r_pf_addr;
    logic                  r_pf_active;
    logic                  w_hit;
    logic                  w_room;
    logic                  w_miss;
    logic                  w_flush;
    logic                  w_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(PF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_room = r_count < CNT_W'(PF_DEPTH);
    assign w_hit  = (r_count != '0) && (r_tag[r_rd_ptr] == w_addr);

    always_comb begin
        w_issue      = 1'b0;
        w_issue_addr = w_addr;
        w_mem_write  = 1'b0;
        w_rd_done    = 1'b0;
        w_rd_data    = r_data[r_rd_ptr];
        w_waitreq    = bus.ics_dma_cs_i;
        w_miss       = 1'b0;
        w_flush      = 1'b0;
        w_pop        = 1'b0;
        if (reset) begin
            w_waitreq = 1'b1;
        end else if (w_wr_req) begin
            w_mem_write = 1'b1;
            w_flush     = 1'b1;
            w_waitreq   = 1'b0;
        end else if (w_rd_req && !w_hit) begin
            w_miss  = 1'b1;
            w_flush = 1'b1;
            w_issue = 1'b1;
        end else begin
            if (w_rd_req && r_dv[r_rd_ptr]) begin
                w_rd_done = 1'b1;
                w_pop     = 1'b1;
                w_waitreq = 1'b0;
            end
            if (r_pf_active && w_room) begin
                w_issue      = 1'b1;
                w_issue_addr = r_pf_addr;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_dv        <= '0;
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_epoch     <= '0;
            r_pf_active <= 1'b0;
            r_pf_addr   <= '0;
        end else begin
            // Returns from before the last flush carry an old epoch and are dropped.
            if (w_ret && (r_pipe_epoch[RD_LATENCY-1] == r_epoch)) begin
                r_data[r_pipe_slot[RD_LATENCY-1]] <= bus.mem_readdata_i;
                r_dv[r_pipe_slot[RD_LATENCY-1]]   <= 1'b1;
            end
            if (w_flush) begin
                r_epoch  <= r_epoch + 1'b1;
                r_rd_ptr <= '0;
                if (w_miss) begin
                    r_tag[0]    <= w_addr;
                    r_dv[0]     <= 1'b0;
                    r_wr_ptr    <= ptr_inc('0);
                    r_count     <= CNT_W'(1);
                    r_pf_active <= 1'b1;
                    r_pf_addr   <= w_addr + 1'b1;
                end else begin
                    r_wr_ptr    <= '0;
                    r_count     <= '0;
                    r_pf_active <= 1'b0;
                end
            end else begin
                if (w_issue) begin
                    r_tag[r_wr_ptr] <= r_pf_addr;
                    r_dv[r_wr_ptr]  <= 1'b0;
                    r_wr_ptr        <= ptr_inc(r_wr_ptr);
                    r_pf_addr       <= r_pf_addr + 1'b1;
                end
                if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
                r_count <= r_count + CNT_W'(w_issue) - CNT_W'(w_pop);
            end
        end
    end

    always_ff @(posedge clock) begin
        r_pipe_epoch[0] <= w_flush ? r_epoch + 1'b1 : r_epoch;
        r_pipe_slot[0]  <= w_flush ? '0 : r_wr_ptr;
        for (int i = 1; i < RD_LATENCY; i++) begin
            r_pipe_epoch[i] <= r_pipe_epoch[i-1];
            r_pipe_slot[i]  <= r_pipe_slot[i-1];
        end
    end
`else
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [31:0]           r_rdata_q;
    logic [MEM_ADDR_W-1:0] r_rd_addr;

    always_ff @(posedge clock) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rdata_q <= '0;
            r_rd_addr <= '0;
        end else begin
            if (w_issue) r_rd_addr <= w_addr;
            if ((r_state == WAIT) && w_ret) r_rdata_q <= bus.mem_readdata_i;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_issue      = 1'b0;
        w_issue_addr = w_addr;
        w_mem_write  = 1'b0;
        w_rd_done    = 1'b0;
        w_rd_data    = r_rdata_q;
        w_waitreq    = bus.ics_dma_cs_i;
        if (reset) begin
            w_waitreq   = 1'b1;
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_wr_req) begin
                        w_mem_write = 1'b1;
                        w_waitreq   = 1'b0;
                    end else if (w_rd_req) begin
                        w_issue     = 1'b1;
                        w_state_nxt = WAIT;
                    end
                end
                WAIT: if (w_ret) w_state_nxt = RESP;
                RESP: begin
                    // Data is only handed to the read that fetched it; anything else restarts from IDLE.
                    w_state_nxt = IDLE;
                    if (w_rd_req && (w_addr == r_rd_addr)) begin
                        w_rd_done = 1'b1;
                        w_waitreq = 1'b0;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_dma_mem_responder.sv
// Bench for dma_mem_responder: word memory model plus read scoreboard; timing expectations follow DMA_RSP_PREFETCH_EN.
module tb_dma_mem_responder;
    localparam int MEM_ADDR_W = 20;
    localparam int RD_LATENCY = 2;
    localparam int PF_DEPTH   = 4;
`ifdef DMA_RSP_PREFETCH_EN
    localparam bit PF = 1'b1;
`else
    localparam bit PF = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [31:0] exp_q [$];
    logic [31:0] mem_arr [int];
    logic [31:0] ref_mem [int];
    logic [31:0] rd_pipe [RD_LATENCY];

    always #5 clock = ~clock;

    dma_mem_responder_if #(.MEM_ADDR_W(MEM_ADDR_W)) bus ();

    dma_mem_responder #(
        .MEM_ADDR_W(MEM_ADDR_W),
        .RD_LATENCY(RD_LATENCY),
        .PF_DEPTH  (PF_DEPTH)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    function automatic logic [31:0] mem_word(input logic [MEM_ADDR_W-1:0] a);
        return mem_arr.exists(int'(a)) ? mem_arr[int'(a)] : 32'(a);
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        logic [MEM_ADDR_W-1:0] t;
        t = a[MEM_ADDR_W-1:0];
        return ref_mem.exists(int'(t)) ? ref_mem[int'(t)] : 32'(t);
    endfunction

    // Fixed-latency memory: data sampled at the read strobe appears RD_LATENCY cycles later.
    always @(posedge clock) begin
        if (bus.mem_write_o) mem_arr[int'(bus.mem_address_o)] = bus.mem_writedata_o;
        rd_pipe[0] <= bus.mem_read_o ? mem_word(bus.mem_address_o) : 32'hBAD0_0000;
        for (int i = 1; i < RD_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bus.mem_readdata_i = rd_pipe[RD_LATENCY-1];

    task automatic drive_read(input logic [31:0] a, output logic [31:0] data, output int waits,
                              output logic issued0, output bit timeout);
        @(posedge clock); #1;
        bus.ics_dma_address_i = a;
        bus.ics_dma_cs_i      = 1'b1;
        bus.ics_dma_write_i   = 1'b0;
        waits = 0; timeout = 1'b1; issued0 = 1'b0; data = '0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            if (c == 0) issued0 = bus.mem_read_o;
            if (bus.ics_dma_waitreq_o === 1'b0) begin
                data    = bus.ics_dma_readdata_o;
                timeout = 1'b0;
                break;
            end
            waits++;
        end
    endtask

    task automatic drive_write(input logic [31:0] a, input logic [31:0] d, output logic mw,
                               output logic wq, output logic [MEM_ADDR_W-1:0] ma);
        @(posedge clock); #1;
        bus.ics_dma_address_i   = a;
        bus.ics_dma_writedata_i = d;
        bus.ics_dma_cs_i        = 1'b1;
        bus.ics_dma_write_i     = 1'b1;
        @(negedge clock);
        mw = bus.mem_write_o; wq = bus.ics_dma_waitreq_o; ma = bus.mem_address_o;
    endtask

    task automatic go_idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock); #1;
            bus.ics_dma_cs_i    = 1'b0;
            bus.ics_dma_write_i = 1'b0;
        end
    endtask

    task automatic test_reset();
        bus.ics_dma_address_i = 32'h55; bus.ics_dma_writedata_i = 32'h1111_2222;
        bus.ics_dma_cs_i = 1'b1; bus.ics_dma_write_i = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        n_checks++; if (bus.ics_dma_waitreq_o !== 1'b1) begin n_fail++; $display("FAIL reset_waitreq got=%b exp=1", bus.ics_dma_waitreq_o); end
        n_checks++; if (bus.ics_dma_readdata_o !== 32'h0) begin n_fail++; $display("FAIL reset_readdata got=%h exp=0", bus.ics_dma_readdata_o); end
        n_checks++; if (bus.mem_read_o !== 1'b0) begin n_fail++; $display("FAIL reset_mem_read got=%b exp=0", bus.mem_read_o); end
        n_checks++; if (bus.mem_write_o !== 1'b0) begin n_fail++; $display("FAIL reset_mem_write got=%b exp=0", bus.mem_write_o); end
        n_checks++; if (bus.mem_address_o !== '0) begin n_fail++; $display("FAIL reset_mem_address got=%h exp=0", bus.mem_address_o); end
        @(posedge clock); #1;
        reset = 1'b0; bus.ics_dma_cs_i = 1'b0; bus.ics_dma_write_i = 1'b0;
    endtask

    task automatic test_read_latency();
        logic [31:0] d, ex; int w; logic i0; bit to;
        exp_q.push_back(ref_word(32'h10));
        drive_read(32'h10, d, w, i0, to);
        ex = exp_q.pop_front();
        n_checks++; if (i0 !== 1'b1) begin n_fail++; $display("FAIL lat_mem_read_c0 got=%b exp=1", i0); end
        n_checks++; if (to || w != RD_LATENCY + 1) begin n_fail++; $display("FAIL lat_waits got=%0d exp=%0d timeout=%0d", w, RD_LATENCY + 1, to); end
        n_checks++; if (to || d !== ex) begin n_fail++; $display("FAIL lat_data got=%h exp=%h", d, ex); end
        go_idle(1);
        @(negedge clock);
        n_checks++; if (bus.ics_dma_readdata_o !== ex) begin n_fail++; $display("FAIL lat_hold got=%h exp=%h", bus.ics_dma_readdata_o, ex); end
        n_checks++; if (bus.ics_dma_waitreq_o !== 1'b0) begin n_fail++; $display("FAIL lat_idle_waitreq got=%b exp=0", bus.ics_dma_waitreq_o); end
    endtask

    task automatic test_write();
        logic [31:0] d, ex; int w; logic i0, mw, wq; bit to; logic [MEM_ADDR_W-1:0] ma;
        drive_write(32'h20, 32'hDEAD_BEEF, mw, wq, ma);
        ref_mem[32'h20] = 32'hDEAD_BEEF;
        n_checks++; if (mw !== 1'b1) begin n_fail++; $display("FAIL wr_strobe got=%b exp=1", mw); end
        n_checks++; if (wq !== 1'b0) begin n_fail++; $display("FAIL wr_waitreq got=%b exp=0", wq); end
        n_checks++; if (ma !== MEM_ADDR_W'(32'h20)) begin n_fail++; $display("FAIL wr_address got=%h exp=20", ma); end
        exp_q.push_back(ref_word(32'h20));
        drive_read(32'h20, d, w, i0, to);
        ex = exp_q.pop_front();
        n_checks++; if (to || d !== ex || w != RD_LATENCY + 1) begin n_fail++; $display("FAIL wr_readback got=%h waits=%0d exp=%h waits=%0d", d, w, ex, RD_LATENCY + 1); end
        go_idle(2);
    endtask

    task automatic test_burst();
        logic [31:0] d, ex, a; int w, ew, total; logic i0; bit to;
        total = 0;
        for (int i = 0; i < 8; i++) begin
            a = 32'h100 + 32'(i);
            exp_q.push_back(ref_word(a));
            drive_read(a, d, w, i0, to);
            ex = exp_q.pop_front();
            ew = (PF && i > 0) ? 0 : RD_LATENCY + 1;
            total += w + 1;
            n_checks++; if (to || d !== ex) begin n_fail++; $display("FAIL burst_data addr=%h got=%h exp=%h", a, d, ex); end
            n_checks++; if (w != ew) begin n_fail++; $display("FAIL burst_waits addr=%h got=%0d exp=%0d", a, w, ew); end
        end
        ew = PF ? (RD_LATENCY + 1 + 8) : 8 * (RD_LATENCY + 2);
        n_checks++; if (total != ew) begin n_fail++; $display("FAIL burst_cycles got=%0d exp=%0d", total, ew); end
        go_idle(3);
    endtask

    task automatic test_miss_flush();
        logic [31:0] d, ex; int w, ew; logic i0; bit to;
        logic [31:0] addrs [4];
        addrs = '{32'h100, 32'h101, 32'h200, 32'h201};
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(ref_word(addrs[i]));
            drive_read(addrs[i], d, w, i0, to);
            ex = exp_q.pop_front();
            ew = (PF && (i == 1 || i == 3)) ? 0 : RD_LATENCY + 1;
            n_checks++; if (to || d !== ex) begin n_fail++; $display("FAIL miss_data addr=%h got=%h exp=%h", addrs[i], d, ex); end
            n_checks++; if (w != ew) begin n_fail++; $display("FAIL miss_waits addr=%h got=%0d exp=%0d", addrs[i], w, ew); end
        end
    endtask

    task automatic test_write_flush();
        logic [31:0] d, ex; int w; logic i0, mw, wq; bit to; logic [MEM_ADDR_W-1:0] ma;
        exp_q.push_back(ref_word(32'h40));
        drive_read(32'h40, d, w, i0, to);
        ex = exp_q.pop_front();
        n_checks++; if (to || d !== ex) begin n_fail++; $display("FAIL wflush_first got=%h exp=%h", d, ex); end
        drive_write(32'h41, 32'h1234, mw, wq, ma);
        ref_mem[32'h41] = 32'h1234;
        n_checks++; if (mw !== 1'b1 || wq !== 1'b0) begin n_fail++; $display("FAIL wflush_accept strobe=%b waitreq=%b exp 1/0", mw, wq); end
        exp_q.push_back(ref_word(32'h41));
        drive_read(32'h41, d, w, i0, to);
        ex = exp_q.pop_front();
        n_checks++; if (to || d !== ex) begin n_fail++; $display("FAIL wflush_data got=%h exp=%h", d, ex); end
        n_checks++; if (w != RD_LATENCY + 1) begin n_fail++; $display("FAIL wflush_waits got=%0d exp=%0d", w, RD_LATENCY + 1); end
    endtask

    task automatic test_alias();
        logic [31:0] d, ex; int w; logic i0; bit to;
        exp_q.push_back(ref_word(32'h0010_0010));
        drive_read(32'h0010_0010, d, w, i0, to);
        ex = exp_q.pop_front();
        n_checks++; if (to || d !== ex) begin n_fail++; $display("FAIL alias_data got=%h exp=%h", d, ex); end
        go_idle(1);
    endtask

    task automatic test_reset_mid_read();
        logic [31:0] d, ex; int w; logic i0; bit to;
        @(posedge clock); #1;
        bus.ics_dma_address_i = 32'h30; bus.ics_dma_cs_i = 1'b1; bus.ics_dma_write_i = 1'b0;
        @(negedge clock);
        n_checks++; if (bus.mem_read_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_issue got=%b exp=1", bus.mem_read_o); end
        @(posedge clock); #1;
        reset = 1'b1; bus.ics_dma_cs_i = 1'b0;
        @(negedge clock);
        n_checks++; if (bus.ics_dma_waitreq_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_waitreq got=%b exp=1", bus.ics_dma_waitreq_o); end
        n_checks++; if (bus.ics_dma_readdata_o !== 32'h0) begin n_fail++; $display("FAIL rstmid_readdata got=%h exp=0", bus.ics_dma_readdata_o); end
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        n_checks++; if (bus.ics_dma_waitreq_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_idle got=%b exp=0", bus.ics_dma_waitreq_o); end
        exp_q.push_back(ref_word(32'h10));
        drive_read(32'h10, d, w, i0, to);
        ex = exp_q.pop_front();
        n_checks++; if (to || d !== ex || w != RD_LATENCY + 1) begin n_fail++; $display("FAIL rstmid_read got=%h waits=%0d exp=%h waits=%0d", d, w, ex, RD_LATENCY + 1); end
        go_idle(1);
    endtask

    initial begin
        bus.ics_dma_address_i   = '0;
        bus.ics_dma_cs_i        = 1'b0;
        bus.ics_dma_write_i     = 1'b0;
        bus.ics_dma_writedata_i = '0;
        mem_arr[32'h10] = 32'hA5A5_A5A5;
        ref_mem[32'h10] = 32'hA5A5_A5A5;
        test_reset();
        test_read_latency();
        test_write();
        test_burst();
        test_miss_flush();
        test_write_flush();
        test_alias();
        test_reset_mid_read();
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end
endmodule
